// File: rtl/vend_slot_ctrl_if.sv
// rtl/vend_slot_ctrl_if.sv - vending slot controller port bundle
// Groups the sale/restock inputs and the display/change outputs of vend_slot_ctrl.
interface vend_slot_ctrl_if #(
    parameter int N_SLOTS = 4,
    parameter int CAP     = 15,
    parameter int PRICE_W = 6
);
    localparam int STOCK_W  = $clog2(CAP + 1);
    localparam int CREDIT_W = PRICE_W + 1;

    logic [N_SLOTS-1:0]         sel;
    logic                       mode;
    logic [N_SLOTS*PRICE_W-1:0] price;
    logic                       coin_vld;
    logic [PRICE_W-1:0]         coin_val;
    logic                       cancel;
    logic                       add_vld;
    logic [STOCK_W-1:0]         add_qty;
    logic                       change_ack;
    logic [N_SLOTS*STOCK_W-1:0] stock;
    logic [CREDIT_W-1:0]        credit;
    logic [2:0]                 state;
    logic                       vend;
    logic [3:0]                 vend_slot;
    logic                       change_vld;
    logic [CREDIT_W-1:0]        change_amt;
    logic                       soldout;
    logic                       clip;

    modport slave (
        input  sel, mode, price, coin_vld, coin_val, cancel, add_vld, add_qty, change_ack,
        output stock, credit, state, vend, vend_slot, change_vld, change_amt, soldout, clip
    );

    modport master (
        output sel, mode, price, coin_vld, coin_val, cancel, add_vld, add_qty, change_ack,
        input  stock, credit, state, vend, vend_slot, change_vld, change_amt, soldout, clip
    );
endinterface

// File: rtl/vend_slot_ctrl.sv
// rtl/vend_slot_ctrl.sv - N-slot vending controller: stock, credit, dispense, change/refund
// Optional PAY idle auto-refund is enabled by defining VEND_TIMEOUT_EN.
module vend_slot_ctrl #(
    parameter int N_SLOTS = 4,
    parameter int CAP     = 15,
    parameter int PRICE_W = 6,
    parameter int TIMEOUT = 50_000_000
) (
    input logic              clk,
    input logic              rst_n,
    vend_slot_ctrl_if.slave  bus
);
    localparam int STOCK_W  = $clog2(CAP + 1);
    localparam int CREDIT_W = PRICE_W + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PAY      = 3'd1,
        S_DISPENSE = 3'd2,
        S_CHANGE   = 3'd3
    } state_t;

    state_t              r_state;
    logic [STOCK_W-1:0]  r_stock [N_SLOTS];
    logic [CREDIT_W-1:0] r_credit;
    logic [3:0]          r_slot;
    logic                r_vend;
    logic                r_change_vld;
    logic [CREDIT_W-1:0] r_change_amt;
    logic                r_soldout;
    logic                r_clip;

    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [3:0]          w_slot_nxt;
    logic                w_vend_nxt;
    logic                w_change_vld_nxt;
    logic [CREDIT_W-1:0] w_change_amt_nxt;
    logic                w_soldout_nxt;
    logic                w_clip_nxt;
    logic                w_stock_dec;
    logic                w_stock_add;
    logic [STOCK_W-1:0]  w_add_amt;

    logic                w_sel_ok;
    logic [3:0]          w_sel_idx;
    logic [STOCK_W-1:0]  w_sel_stock;
    logic [STOCK_W-1:0]  w_room;
    logic [PRICE_W-1:0]  w_price;
    logic [CREDIT_W-1:0] w_price_ext;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_credit_upd;
    logic [CREDIT_W-1:0] w_diff;
    logic                w_abort;
    logic                w_tmo_hit;

    always_comb begin
        w_sel_ok  = $onehot(bus.sel);
        w_sel_idx = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (bus.sel[i]) w_sel_idx = 4'(i);
        end
    end

    always_comb begin
        w_sel_stock = '0;
        w_price     = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (w_sel_idx == 4'(i)) w_sel_stock = r_stock[i];
            if (r_slot == 4'(i))    w_price     = bus.price[i*PRICE_W +: PRICE_W];
        end
    end

    assign w_room       = STOCK_W'(CAP) - w_sel_stock;
    assign w_price_ext  = {1'b0, w_price};
    assign w_sum        = {1'b0, r_credit} + {2'b00, bus.coin_val};
    assign w_credit_upd = !bus.coin_vld ? r_credit :
                          (w_sum[CREDIT_W] ? '1 : w_sum[CREDIT_W-1:0]);
    assign w_diff       = r_credit - w_price_ext;

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TMO_W-1:0] r_tmo;

    // Counter only runs while waiting in PAY; a coin restarts the idle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_tmo <= '0;
        else if (r_state != S_PAY || bus.coin_vld) r_tmo <= '0;
        else                                       r_tmo <= r_tmo + TMO_W'(1);
    end

    assign w_tmo_hit = (r_state == S_PAY) && !bus.coin_vld && (r_tmo == TMO_W'(TIMEOUT - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    assign w_abort = bus.cancel || !w_sel_ok || (w_sel_idx != r_slot) || bus.mode || w_tmo_hit;

    always_comb begin
        w_state_nxt      = r_state;
        w_credit_nxt     = r_credit;
        w_slot_nxt       = r_slot;
        w_vend_nxt       = 1'b0;
        w_change_vld_nxt = r_change_vld;
        w_change_amt_nxt = r_change_amt;
        w_soldout_nxt    = 1'b0;
        w_clip_nxt       = 1'b0;
        w_stock_dec      = 1'b0;
        w_stock_add      = 1'b0;
        w_add_amt        = '0;
        case (r_state)
            S_IDLE: begin
                w_credit_nxt = '0;
                if (w_sel_ok && !bus.mode) begin
                    if (w_sel_stock != '0) begin
                        w_state_nxt = S_PAY;
                        w_slot_nxt  = w_sel_idx;
                    end else begin
                        w_soldout_nxt = 1'b1;
                    end
                end else if (w_sel_ok && bus.mode && bus.add_vld) begin
                    w_stock_add = 1'b1;
                    if (bus.add_qty > w_room) begin
                        w_add_amt  = w_room;
                        w_clip_nxt = 1'b1;
                    end else begin
                        w_add_amt  = bus.add_qty;
                    end
                end
            end
            S_PAY: begin
                // Abort takes priority so a same-cycle coin lands in the refund, never a vend.
                if (w_abort) begin
                    w_credit_nxt = '0;
                    if (w_credit_upd != '0) begin
                        w_state_nxt      = S_CHANGE;
                        w_change_vld_nxt = 1'b1;
                        w_change_amt_nxt = w_credit_upd;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_credit_nxt = w_credit_upd;
                    if (bus.coin_vld && w_credit_upd >= w_price_ext) begin
                        w_state_nxt = S_DISPENSE;
                        w_vend_nxt  = 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                w_stock_dec  = 1'b1;
                w_credit_nxt = '0;
                if (w_diff != '0) begin
                    w_state_nxt      = S_CHANGE;
                    w_change_vld_nxt = 1'b1;
                    w_change_amt_nxt = w_diff;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHANGE: begin
                if (bus.change_ack) begin
                    w_state_nxt      = S_IDLE;
                    w_change_vld_nxt = 1'b0;
                    w_change_amt_nxt = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_credit     <= '0;
            r_slot       <= '0;
            r_vend       <= 1'b0;
            r_change_vld <= 1'b0;
            r_change_amt <= '0;
            r_soldout    <= 1'b0;
            r_clip       <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) r_stock[i] <= STOCK_W'(CAP);
        end else begin
            r_state      <= w_state_nxt;
            r_credit     <= w_credit_nxt;
            r_slot       <= w_slot_nxt;
            r_vend       <= w_vend_nxt;
            r_change_vld <= w_change_vld_nxt;
            r_change_amt <= w_change_amt_nxt;
            r_soldout    <= w_soldout_nxt;
            r_clip       <= w_clip_nxt;
            for (int i = 0; i < N_SLOTS; i++) begin
                if (w_stock_dec && r_slot == 4'(i))
                    r_stock[i] <= r_stock[i] - STOCK_W'(1);
                else if (w_stock_add && w_sel_idx == 4'(i))
                    r_stock[i] <= r_stock[i] + w_add_amt;
            end
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_stock
        assign bus.stock[g*STOCK_W +: STOCK_W] = r_stock[g];
    end

    assign bus.credit     = r_credit;
    assign bus.state      = r_state;
    assign bus.vend       = r_vend;
    assign bus.vend_slot  = r_slot;
    assign bus.change_vld = r_change_vld;
    assign bus.change_amt = r_change_amt;
    assign bus.soldout    = r_soldout;
    assign bus.clip       = r_clip;
endmodule

// File: tb/tb_vend_slot_ctrl.sv
// tb/tb_vend_slot_ctrl.sv - directed self-checking bench for vend_slot_ctrl
// Prices: slot0=3, slot1=9, slot2=7, slot3=5; TIMEOUT=20 for the VEND_TIMEOUT_EN build.
module tb_vend_slot_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    vend_slot_ctrl_if #(.N_SLOTS(4), .CAP(15), .PRICE_W(6)) bus ();

    vend_slot_ctrl #(.N_SLOTS(4), .CAP(15), .PRICE_W(6), .TIMEOUT(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        chk("rst_stock", int'(bus.stock), 16'hFFFF);
        chk("rst_credit", int'(bus.credit), 0);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_vend", int'(bus.vend), 0);
        chk("rst_change_vld", int'(bus.change_vld), 0);
        chk("rst_change_amt", int'(bus.change_amt), 0);
        chk("rst_soldout", int'(bus.soldout), 0);
        chk("rst_clip", int'(bus.clip), 0);
    endtask

    task automatic test_sale_change();
        bus.sel = 4'b0100;
        step();
        chk("sale_state_pay", int'(bus.state), 1);
        chk("sale_vend_slot", int'(bus.vend_slot), 2);
        bus.coin_vld = 1'b1; bus.coin_val = 6'd5;
        step();
        chk("sale_credit5", int'(bus.credit), 5);
        chk("sale_no_vend_yet", int'(bus.vend), 0);
        step();
        bus.coin_vld = 1'b0;
        chk("sale_state_disp", int'(bus.state), 2);
        chk("sale_vend", int'(bus.vend), 1);
        chk("sale_credit10", int'(bus.credit), 10);
        step();
        chk("sale_stock2", int'(bus.stock[11:8]), 14);
        chk("sale_change_vld", int'(bus.change_vld), 1);
        chk("sale_change_amt", int'(bus.change_amt), 3);
        chk("sale_vend_off", int'(bus.vend), 0);
        chk("sale_credit_clr", int'(bus.credit), 0);
        bus.sel = 4'b0000;
        step();
        chk("sale_amt_hold", int'(bus.change_amt), 3);
        bus.change_ack = 1'b1;
        step();
        bus.change_ack = 1'b0;
        chk("sale_ack_vld", int'(bus.change_vld), 0);
        chk("sale_ack_amt", int'(bus.change_amt), 0);
        chk("sale_ack_idle", int'(bus.state), 0);
    endtask

    task automatic test_cancel();
        bus.sel = 4'b0010;
        step();
        bus.coin_vld = 1'b1; bus.coin_val = 6'd4;
        step();
        chk("cancel_credit4", int'(bus.credit), 4);
        bus.coin_val = 6'd2; bus.cancel = 1'b1;
        step();
        bus.coin_vld = 1'b0; bus.cancel = 1'b0;
        chk("cancel_state", int'(bus.state), 3);
        chk("cancel_amt", int'(bus.change_amt), 6);
        chk("cancel_vld", int'(bus.change_vld), 1);
        chk("cancel_no_vend", int'(bus.vend), 0);
        chk("cancel_stock1", int'(bus.stock[7:4]), 15);
        bus.sel = 4'b0000; bus.change_ack = 1'b1;
        step();
        bus.change_ack = 1'b0;
        chk("cancel_idle", int'(bus.state), 0);
        bus.sel = 4'b0010;
        step();
        bus.sel = 4'b0000;
        step();
        chk("desel_zero_idle", int'(bus.state), 0);
        chk("desel_zero_novld", int'(bus.change_vld), 0);
        bus.change_ack = 1'b1;
        step();
        bus.change_ack = 1'b0;
        chk("stray_ack_idle", int'(bus.state), 0);
        chk("stray_ack_novld", int'(bus.change_vld), 0);
    endtask

    task automatic sell_exact(input logic [3:0] s, input logic [5:0] p, output int vends);
        vends = 0;
        bus.sel = s;
        step();
        bus.coin_vld = 1'b1; bus.coin_val = p;
        step();
        bus.coin_vld = 1'b0;
        if (bus.vend === 1'b1) vends = 1;
        bus.sel = 4'b0000;
        step();
    endtask

    task automatic test_soldout();
        int v;
        int total;
        total = 0;
        for (int i = 0; i < 15; i++) begin
            sell_exact(4'b0001, 6'd3, v);
            total += v;
        end
        chk("drain_vends", total, 15);
        chk("drain_stock0", int'(bus.stock[3:0]), 0);
        chk("drain_nochange", int'(bus.change_vld), 0);
        bus.sel = 4'b0001;
        step();
        chk("soldout_pulse", int'(bus.soldout), 1);
        chk("soldout_idle", int'(bus.state), 0);
        bus.sel = 4'b0000;
        step();
        chk("soldout_clear", int'(bus.soldout), 0);
        chk("soldout_still_idle", int'(bus.state), 0);
    endtask

    task automatic test_restock();
        int v;
        for (int i = 0; i < 5; i++) sell_exact(4'b1000, 6'd5, v);
        chk("rs_stock3_10", int'(bus.stock[15:12]), 10);
        bus.mode = 1'b1; bus.sel = 4'b1000; bus.add_vld = 1'b1; bus.add_qty = 4'd8;
        step();
        bus.add_vld = 1'b0;
        chk("rs_clip_stock", int'(bus.stock[15:12]), 15);
        chk("rs_clip_pulse", int'(bus.clip), 1);
        step();
        chk("rs_clip_clear", int'(bus.clip), 0);
        bus.add_vld = 1'b1; bus.add_qty = 4'd0;
        step();
        bus.add_vld = 1'b0;
        chk("rs_zero_stock", int'(bus.stock[15:12]), 15);
        chk("rs_zero_noclip", int'(bus.clip), 0);
        bus.sel = 4'b0001; bus.add_vld = 1'b1; bus.add_qty = 4'd7;
        step();
        chk("rs_slot0_7", int'(bus.stock[3:0]), 7);
        chk("rs_slot0_noclip", int'(bus.clip), 0);
        bus.add_qty = 4'd8;
        step();
        bus.add_vld = 1'b0;
        chk("rs_exact_fill", int'(bus.stock[3:0]), 15);
        chk("rs_exact_noclip", int'(bus.clip), 0);
        chk("rs_state_idle", int'(bus.state), 0);
        bus.mode = 1'b0; bus.sel = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        bus.sel = 4'b0010;
        step();
        bus.coin_vld = 1'b1; bus.coin_val = 6'd3;
        step();
        bus.coin_vld = 1'b0;
        chk("tmo_credit3", int'(bus.credit), 3);
`ifdef VEND_TIMEOUT_EN
        repeat (19) step();
        chk("tmo_before", int'(bus.state), 1);
        step();
        chk("tmo_state", int'(bus.state), 3);
        chk("tmo_vld", int'(bus.change_vld), 1);
        chk("tmo_amt", int'(bus.change_amt), 3);
`else
        repeat (1000) step();
        chk("notmo_state", int'(bus.state), 1);
        chk("notmo_credit", int'(bus.credit), 3);
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        chk("notmo_refund", int'(bus.change_amt), 3);
`endif
        bus.sel = 4'b0000; bus.change_ack = 1'b1;
        step();
        bus.change_ack = 1'b0;
        chk("tmo_idle", int'(bus.state), 0);
        chk("tmo_stock1", int'(bus.stock[7:4]), 15);
    endtask

    initial begin
        bus.sel = '0; bus.mode = 1'b0; bus.coin_vld = 1'b0; bus.coin_val = '0;
        bus.cancel = 1'b0; bus.add_vld = 1'b0; bus.add_qty = '0; bus.change_ack = 1'b0;
        bus.price = {6'd5, 6'd7, 6'd9, 6'd3};
        repeat (3) step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_sale_change();
        test_cancel();
        test_soldout();
        test_restock();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
